mem_access_sequencer: RTL and testbench

- CPU-side initiator for the main-memory port; the control unit issues fetch, load and store requests here instead of driving memory directly.
- Owns MAR and MBR and sequences one synchronous single-port memory access per request.
- Returns read data or store completion over a valid/ready response channel.
- Sits between the control FSM and MainMemory (16-bit word interface, 1-cycle synchronous read).

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_seq_fsm.sv | 73 +++++++
 rtl/mem_access_sequencer.sv | 88 ++++++++
 tb/tb_mem_access_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory access sequencer: request opcodes and FSM states.
package mem_pkg;

    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

endpackage

// File: rtl/mem_seq_fsm.sv
// Control FSM for one memory access per request; all outputs are registered.
//   state      | meaning
//   ST_IDLE    | ready for a request, MAR/MBR load on acceptance
//   ST_ISSUE   | address on the memory port, write strobe for stores
//   ST_CAPTURE | read data valid on mem_data_out, MBR loads it
//   ST_RESP    | response held until rsp_ready
module mem_seq_fsm
    import mem_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   req_valid,
    input  logic   req_bad,
    input  logic   req_store,
    input  logic   rsp_ready,
    output state_e state,
    output logic   req_ready,
    output logic   rsp_valid,
    output logic   mem_write_enable
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            req_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            mem_write_enable <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state            <= ST_ISSUE;
                            mem_write_enable <= req_store;
                        end
                    end
                end
                ST_ISSUE: begin
                    // the write strobe doubles as the "this is a store" flag
                    mem_write_enable <= 1'b0;
                    if (mem_write_enable) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    req_ready        <= 1'b1;
                    rsp_valid        <= 1'b0;
                    mem_write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// CPU-side main-memory initiator: owns MAR/MBR and runs one synchronous access per request.
module mem_access_sequencer
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 16384
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_op,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mbr_q
);

    // one extra bit so a MEM_WORDS equal to 2**ADDR_W does not truncate to zero
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    state_e state;
    logic   req_bad;
    logic   req_store;
    logic   accept;

    assign req_bad   = ({1'b0, req_addr} >= MEM_LIMIT) || (req_op == OP_RSVD);
    assign req_store = (req_op == OP_STORE);
    assign accept    = (state == ST_IDLE) && req_valid;

    mem_seq_fsm u_fsm (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_bad          (req_bad),
        .req_store        (req_store),
        .rsp_ready        (rsp_ready),
        .state            (state),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .mem_write_enable (mem_write_enable)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mar_q <= '0;
        end else if (accept) begin
            mar_q <= req_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mbr_q <= '0;
        end else if (accept) begin
            mbr_q <= req_bad ? '0 : req_wdata;
        end else if ((state == ST_ISSUE) && mem_write_enable) begin
            mbr_q <= '0;
        end else if (state == ST_CAPTURE) begin
            mbr_q <= mem_data_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_op  <= '0;
            rsp_err <= 1'b0;
        end else if (accept) begin
            rsp_op  <= req_op;
            rsp_err <= req_bad;
        end
    end

    assign rsp_data    = mbr_q;
    assign mem_addr    = mar_q;
    assign mem_data_in = mbr_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a 1-cycle synchronous memory model.
module tb_mem_access_sequencer;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_write_enable;
    logic [15:0] mem_data_out;
    logic [15:0] mar_q;
    logic [15:0] mbr_q;

    logic [15:0] mem [0:16383];
    logic        pl_en = 1'b0;
    logic [13:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          prev_acc = 0;
    int          we_cnt = 0;
    logic [15:0] we_addr = '0;
    logic [15:0] we_data = '0;
    logic        prev_rv = 1'b0;

    mem_access_sequencer #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(16384)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_op           (rsp_op),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out),
        .mar_q            (mar_q),
        .mbr_q            (mbr_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (mem_write_enable)
            mem[mem_addr[13:0]] <= mem_data_in;
        mem_data_out <= mem[mem_addr[13:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // response scoreboard: latency on the rising edge of rsp_valid, payload on handshake
    always @(negedge clk) begin
        prev_rv <= rsp_valid;
        if (mem_write_enable) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_addr;
            we_data <= mem_data_in;
        end
        if (rsp_valid && !prev_rv) begin
            chk("rsp_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("latency", 32'(cyc - last_acc), 32'(exp_q[0].lat));
        end
        if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
            chk("rsp_op", 32'(rsp_op), 32'(exp_q[0].op));
            chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
            chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
            void'(exp_q.pop_front());
        end
    end

    task automatic expect_rsp(input logic [1:0] op, input logic [15:0] data, input logic err, input int lat);
        exp_t e;
        e.op = op; e.data = data; e.err = err; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic preload(input logic [13:0] addr, input logic [15:0] data);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd);
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
                prev_acc  = last_acc;
                last_acc  = cyc;
                return;
            end
            @(posedge clk); #1;
        end
        chk("accept_timeout", 32'(req_ready), 1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_we", 32'(mem_write_enable), 0);
        chk("rst_mar", 32'(mar_q), 0);
        chk("rst_mbr", 32'(mbr_q), 0);
        chk("rst_rsp_op", 32'(rsp_op), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        preload(14'h0010, 16'hBEEF);
        preload(14'h3FFF, 16'h7A5C);
        preload(14'h0030, 16'h5555);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 1);

        // fetch
        w0 = we_cnt;
        expect_rsp(OP_FETCH, 16'hBEEF, 1'b0, 2);
        send(OP_FETCH, 16'h0010, 16'h0000);
        drain();
        chk("fetch_no_write", 32'(we_cnt - w0), 0);

        // store then load back
        w0 = we_cnt;
        expect_rsp(OP_STORE, 16'h0000, 1'b0, 1);
        send(OP_STORE, 16'h0020, 16'h1234);
        drain();
        chk("store_we_cycles", 32'(we_cnt - w0), 1);
        chk("store_we_addr", 32'(we_addr), 32'h0020);
        chk("store_we_data", 32'(we_data), 32'h1234);
        expect_rsp(OP_LOAD, 16'h1234, 1'b0, 2);
        send(OP_LOAD, 16'h0020, 16'h0000);
        drain();

        // out-of-range address, reserved op, last legal word
        w0 = we_cnt;
        expect_rsp(OP_LOAD, 16'h0000, 1'b1, 0);
        send(OP_LOAD, 16'h4000, 16'hFFFF);
        drain();
        expect_rsp(OP_RSVD, 16'h0000, 1'b1, 0);
        send(OP_RSVD, 16'h0001, 16'hAAAA);
        drain();
        chk("err_no_write", 32'(we_cnt - w0), 0);
        expect_rsp(OP_LOAD, 16'h7A5C, 1'b0, 2);
        send(OP_LOAD, 16'h3FFF, 16'h0000);
        drain();

        // back-pressure: response holds, second request waits for the handshake
        rsp_ready = 1'b0;
        expect_rsp(OP_LOAD, 16'hBEEF, 1'b0, 2);
        send(OP_LOAD, 16'h0010, 16'h0000);
        for (int i = 0; i < 10 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("hold_rsp_valid_up", 32'(rsp_valid), 1);
        expect_rsp(OP_LOAD, 16'h7A5C, 1'b0, 2);
        req_op = OP_LOAD; req_addr = 16'h3FFF; req_wdata = 16'h0000; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 1);
            chk("hold_rsp_data", 32'(rsp_data), 32'hBEEF);
            chk("hold_rsp_op", 32'(rsp_op), 32'(OP_LOAD));
            chk("hold_req_ready", 32'(req_ready), 0);
            chk("hold_mar", 32'(mar_q), 32'h0010);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_req_ready", 32'(req_ready), 1);
        chk("post_hs_mar", 32'(mar_q), 32'h0010);
        chk("post_hs_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        last_acc = cyc;
        req_valid = 1'b0;
        chk("second_accept_mar", 32'(mar_q), 32'h3FFF);
        chk("second_accept_ready", 32'(req_ready), 0);
        drain();

        // reset during the ISSUE cycle of a store
        w0 = we_cnt;
        send(OP_STORE, 16'h0030, 16'hDEAD);
        chk("issue_we_high", 32'(mem_write_enable), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_we_drop", 32'(mem_write_enable), 0);
        chk("async_mar", 32'(mar_q), 0);
        chk("async_mbr", 32'(mbr_q), 0);
        chk("async_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_req_ready", 32'(req_ready), 1);
        chk("rst_mem_0030", 32'(mem[14'h0030]), 32'h5555);
        chk("rst_no_write", 32'(we_cnt - w0), 0);

        // back-to-back alternating store/load
        w0 = we_cnt;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a, d;
            a = 16'h0100 + 16'(i / 2);
            d = 16'h1111 * 16'(i / 2 + 1);
            if (i % 2 == 0) begin
                expect_rsp(OP_STORE, 16'h0000, 1'b0, 1);
                send(OP_STORE, a, d);
            end else begin
                expect_rsp(OP_LOAD, d, 1'b0, 2);
                send(OP_LOAD, a, 16'h0000);
            end
            if (i > 0) chk("throughput", 32'(last_acc - prev_acc), (i % 2 == 1) ? 32'd3 : 32'd4);
        end
        drain();
        chk("b2b_we_cycles", 32'(we_cnt - w0), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
